// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 4-bit-opcode CPU
//
// Purpose: steps each instruction through one state per cycle and drives the
// PC, IR, register-file, ALU and memory strobes. Memory accesses (FETCH, MEM)
// are held until mem_ready; a bounded wait counter turns a stuck memory into
// a sticky FAULT, as does an illegal opcode.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode[3:0]         IR opcode field, stable from DECODE until next ir_write
//   zero                ALU zero flag (BEQ decision in EXEC)
//   mem_ready           memory completed the current request this cycle
//   state[2:0]          current state (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 FAULT=7)
//   pc_write, pc_src    PC load strobe and source (00 PC+1, 01 branch, 10 jump)
//   ir_write            IR load strobe
//   mem_req, mem_we     memory request (held until ready) and write qualifier
//   mem_addr_sel        memory address source (0 PC, 1 ALU result)
//   reg_write, reg_dst  register write strobe, destination (1 rd, 0 rt)
//   mem_to_reg          write-back source (1 memory data, 0 ALU result)
//   alu_op, alu_src     ALU operation (00 add 01 sub 10 and 11 or), B source
//   instr_done          one-cycle pulse on the last cycle of each instruction
//   fault               sticky fault indication

module multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       instr_done,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b0110;
    localparam logic [3:0] OP_JMP = 4'b0111;

    // Count value in the last cycle a request may remain unanswered.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign state = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        ir_write     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_op       = 2'b00;
        alu_src      = 1'b0;
        instr_done   = 1'b0;
        fault        = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (opcode[3]) begin
                    state_d = S_FAULT;
                end else if (opcode == OP_JMP) begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode[3:2] == 2'b00) begin
                    alu_op  = opcode[1:0];
                    state_d = S_WB;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    alu_src = 1'b1;
                    state_d = S_MEM;
                end else if (opcode == OP_BEQ) begin
                    alu_op     = 2'b01;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                    if (zero) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b01;
                    end
                end else begin
                    // Opcode changed under us after DECODE; treat as illegal.
                    state_d = S_FAULT;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                alu_src      = 1'b1;
                mem_we       = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                reg_dst    = (opcode[3:2] == 2'b00);
                mem_to_reg = (opcode == OP_LW);
                state_d    = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (!mem_ready && (state_q == S_FETCH || state_q == S_MEM)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Reset aborts whatever is in flight: no strobe may escape this cycle.
        if (rst) begin
            state_d      = S_FETCH;
            cnt_d        = '0;
            pc_write     = 1'b0;
            pc_src       = 2'b00;
            ir_write     = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            reg_write    = 1'b0;
            reg_dst      = 1'b0;
            mem_to_reg   = 1'b0;
            alu_op       = 2'b00;
            alu_src      = 1'b0;
            instr_done   = 1'b0;
            fault        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'b0000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       instr_done;
    logic       fault;

    multicycle_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .state(state), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .alu_src(alu_src), .instr_done(instr_done), .fault(fault)
    );

    always #5 clk = ~clk;

    // Packed output vector:
    // [17:15] state [14] pc_write [13:12] pc_src [11] ir_write [10] mem_req
    // [9] mem_we [8] mem_addr_sel [7] reg_write [6] reg_dst [5] mem_to_reg
    // [4:3] alu_op [2] alu_src [1] instr_done [0] fault
    localparam logic [17:0] PCW   = 18'(1) << 14;
    localparam logic [17:0] PCS_B = 18'(1) << 12;
    localparam logic [17:0] PCS_J = 18'(2) << 12;
    localparam logic [17:0] IRW   = 18'(1) << 11;
    localparam logic [17:0] MREQ  = 18'(1) << 10;
    localparam logic [17:0] MWE   = 18'(1) << 9;
    localparam logic [17:0] MAS   = 18'(1) << 8;
    localparam logic [17:0] RW    = 18'(1) << 7;
    localparam logic [17:0] RD    = 18'(1) << 6;
    localparam logic [17:0] M2R   = 18'(1) << 5;
    localparam logic [17:0] ASRC  = 18'(1) << 2;
    localparam logic [17:0] DONE  = 18'(1) << 1;
    localparam logic [17:0] FLT   = 18'(1);

    function automatic logic [17:0] st(input int s);
        return 18'(s) << 15;
    endfunction

    function automatic logic [17:0] aop(input logic [1:0] op);
        return 18'(op) << 3;
    endfunction

    typedef struct {
        logic        rst;
        logic        mr;
        logic        zero;
        logic [3:0]  op;
        logic [17:0] exp;
    } step_t;

    step_t plan_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic add_step(input logic r, input logic mr, input logic z,
                            input logic [3:0] op, input logic [17:0] e);
        step_t s;
        s.rst = r; s.mr = mr; s.zero = z; s.op = op; s.exp = e;
        plan_q.push_back(s);
    endtask

    // Expected cycle sequence of one instruction, written from the opcode table.
    task automatic add_instr(input logic [3:0] op, input logic z,
                             input int fetch_waits, input int mem_waits);
        for (int i = 0; i < fetch_waits; i++) add_step(0, 0, z, op, st(0) | MREQ);
        add_step(0, 1, z, op, st(0) | MREQ | IRW | PCW);
        if (op == 4'b0111) begin
            add_step(0, 1, z, op, st(1) | PCW | PCS_J | DONE);
        end else if (op[3]) begin
            add_step(0, 1, z, op, st(1));
        end else begin
            add_step(0, 1, z, op, st(1));
            if (op[3:2] == 2'b00) begin
                add_step(0, 1, z, op, st(2) | aop(op[1:0]));
                add_step(0, 1, z, op, st(4) | RW | RD | DONE);
            end else if (op == 4'b0110) begin
                add_step(0, 1, z, op, st(2) | aop(2'b01) | DONE | (z ? (PCW | PCS_B) : 18'd0));
            end else begin
                add_step(0, 1, z, op, st(2) | ASRC);
                for (int i = 0; i < mem_waits; i++)
                    add_step(0, 0, z, op, st(3) | MREQ | MAS | ASRC | (op == 4'b0101 ? MWE : 18'd0));
                if (op == 4'b0101) begin
                    add_step(0, 1, z, op, st(3) | MREQ | MAS | ASRC | MWE | DONE);
                end else begin
                    add_step(0, 1, z, op, st(3) | MREQ | MAS | ASRC);
                    add_step(0, 1, z, op, st(4) | RW | M2R | DONE);
                end
            end
        end
    endtask

    // Drive one cycle of inputs (caller is just after a rising edge), sample
    // outputs on the falling edge, then advance past the next rising edge.
    task automatic cycle(input step_t s, output logic [17:0] got);
        rst = s.rst; mem_ready = s.mr; zero = s.zero; opcode = s.op;
        @(negedge clk);
        got = {state, pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel,
               reg_write, reg_dst, mem_to_reg, alu_op, alu_src, instr_done, fault};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t s; logic [17:0] got; int i = 0;
        add_step(1, 1, 0, 4'b0000, st(0));
        add_step(1, 1, 1, 4'b0111, st(0));
        while (plan_q.size() > 0) begin
            s = plan_q.pop_front();
            cycle(s, got);
            n_checks++;
            if (got !== s.exp) begin
                n_errors++;
                $display("FAIL reset step %0d: got %h expected %h", i, got, s.exp);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s; logic [17:0] got; int i = 0;
        add_instr(4'b0000, 0, 0, 0);
        add_instr(4'b0001, 1, 0, 0);
        add_instr(4'b0010, 0, 2, 0);
        add_instr(4'b0011, 0, 0, 0);
        while (plan_q.size() > 0) begin
            s = plan_q.pop_front();
            cycle(s, got);
            n_checks++;
            if (got !== s.exp) begin
                n_errors++;
                $display("FAIL rtype step %0d: got %h expected %h", i, got, s.exp);
            end
            i++;
        end
    endtask

    task automatic test_mem_ops();
        step_t s; logic [17:0] got; int i = 0;
        add_instr(4'b0100, 0, 0, 3);
        add_instr(4'b0101, 0, 0, 0);
        add_instr(4'b0101, 0, 1, 2);
        while (plan_q.size() > 0) begin
            s = plan_q.pop_front();
            cycle(s, got);
            n_checks++;
            if (got !== s.exp) begin
                n_errors++;
                $display("FAIL lw_sw step %0d: got %h expected %h", i, got, s.exp);
            end
            i++;
        end
    endtask

    task automatic test_branch_jump();
        step_t s; logic [17:0] got; int i = 0;
        add_instr(4'b0110, 1, 0, 0);
        add_instr(4'b0110, 0, 0, 0);
        add_instr(4'b0111, 0, 0, 0);
        add_instr(4'b0000, 0, 0, 0);
        while (plan_q.size() > 0) begin
            s = plan_q.pop_front();
            cycle(s, got);
            n_checks++;
            if (got !== s.exp) begin
                n_errors++;
                $display("FAIL beq_jmp step %0d: got %h expected %h", i, got, s.exp);
            end
            i++;
        end
    endtask

    task automatic test_illegal();
        step_t s; logic [17:0] got; int i = 0;
        add_instr(4'b1010, 0, 0, 0);
        for (int k = 0; k < 20; k++) add_step(0, 1'($urandom_range(0, 1)), 0, 4'b1010, st(7) | FLT);
        add_step(1, 1, 0, 4'b1010, st(7));
        add_instr(4'b0001, 0, 0, 0);
        while (plan_q.size() > 0) begin
            s = plan_q.pop_front();
            cycle(s, got);
            n_checks++;
            if (got !== s.exp) begin
                n_errors++;
                $display("FAIL illegal step %0d: got %h expected %h", i, got, s.exp);
            end
            i++;
        end
    endtask

    task automatic test_timeout();
        step_t s; logic [17:0] got; int i = 0;
        for (int k = 0; k < 15; k++) add_step(0, 0, 0, 4'b0000, st(0) | MREQ);
        add_step(0, 0, 0, 4'b0000, st(7) | FLT);
        add_step(0, 1, 0, 4'b0000, st(7) | FLT);
        add_step(1, 0, 0, 4'b0000, st(7));
        add_instr(4'b0111, 0, 14, 0);
        add_instr(4'b0100, 0, 14, 14);
        while (plan_q.size() > 0) begin
            s = plan_q.pop_front();
            cycle(s, got);
            n_checks++;
            if (got !== s.exp) begin
                n_errors++;
                $display("FAIL timeout step %0d: got %h expected %h", i, got, s.exp);
            end
            i++;
        end
    endtask

    task automatic test_reset_mid_mem();
        step_t s; logic [17:0] got; int i = 0;
        add_step(0, 1, 0, 4'b0100, st(0) | MREQ | IRW | PCW);
        add_step(0, 1, 0, 4'b0100, st(1));
        add_step(0, 1, 0, 4'b0100, st(2) | ASRC);
        add_step(0, 0, 0, 4'b0100, st(3) | MREQ | MAS | ASRC);
        add_step(0, 0, 0, 4'b0100, st(3) | MREQ | MAS | ASRC);
        add_step(1, 1, 0, 4'b0100, st(3));
        add_instr(4'b0011, 0, 0, 0);
        while (plan_q.size() > 0) begin
            s = plan_q.pop_front();
            cycle(s, got);
            n_checks++;
            if (got !== s.exp) begin
                n_errors++;
                $display("FAIL rst_mem step %0d: got %h expected %h", i, got, s.exp);
            end
            i++;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_mem_ops();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 4-bit-opcode CPU.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, one state per cycle.
- Drives PC, IR, register-file, ALU and memory strobes.
- Sits between the instruction register and a shared single-port memory with a ready handshake, replacing the single-cycle decode path.

Parameters:
- TIMEOUT, 15: max consecutive cycles mem_req may stay high without mem_ready before entering FAULT (range 1..255).
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  IR[opcode] field; valid from DECODE onward, held stable until the next ir_write.
- zero  in  1  ALU zero flag; sampled in EXEC for BEQ.
- mem_ready  in  1  memory completed the current request this cycle.
- state  out  3  current state encoding.
- pc_write  out  1  PC load strobe.
- pc_src  out  2  PC source: 00 = PC+1, 01 = branch target, 10 = jump target.
- ir_write  out  1  IR load strobe.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write request; valid only with mem_req.
- mem_addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- reg_write  out  1  register-file write strobe.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back source: 1 = memory data, 0 = ALU result.
- alu_op  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 or.
- alu_src  out  1  ALU B input: 1 = immediate, 0 = register.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- fault  out  1  sticky fault: illegal opcode or memory timeout.

Behaviour:
- State register and wait counter are registered; all other outputs are combinational from state, opcode, zero and mem_ready.
- Any output not driven in a state is 0.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 7.
- Reset: while rst = 1, every output except state is forced to 0. Next state is FETCH and wait counter is 0. A reset during any state, including MEM or FAULT, aborts the instruction with no strobe issued that cycle.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 00, go to DECODE.
- DECODE:
  - Opcodes 1000–1111 go to FAULT.
  - JMP (0111): pc_write = 1, pc_src = 10, instr_done = 1, go to FETCH.
  - All other opcodes go to EXEC.
- EXEC:
  - ADD/SUB/AND/OR (0000–0011): alu_op = opcode[1:0], alu_src = 0, go to WB.
  - LW/SW (0100/0101): alu_op = 00, alu_src = 1, go to MEM.
  - BEQ (0110): alu_op = 01, alu_src = 0, instr_done = 1, go to FETCH. If zero = 1, also pc_write = 1, pc_src = 01.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, alu_src = 1, alu_op = 00; mem_we = 1 for SW only.
  - On mem_ready: SW sets instr_done = 1 and goes to FETCH; LW goes to WB.
- WB:
  - reg_write = 1, instr_done = 1, go to FETCH.
  - R-type: reg_dst = 1. LW: mem_to_reg = 1, reg_dst = 0.
- FAULT:
  - fault = 1, all strobes 0.
  - Stays in FAULT until rst.
- Wait counter:
  - Cleared on every state change.
  - Increments each FETCH/MEM cycle with mem_ready = 0.
  - If mem_ready = 0 in the cycle where the count equals TIMEOUT-1, next state is FAULT.
  - mem_ready = 1 in that same cycle completes normally; ready wins over timeout.
- Minimum latencies (zero-wait memory, FETCH through instr_done):
  - JMP 2, BEQ 3, R-type 4, SW 4, LW 5 cycles.
- Each memory wait cycle adds 1 to these latencies.
- Exactly one instr_done pulse per completed instruction.
- No instr_done for an instruction that faults.

Test Plan:
- Reset, then ADD (0000) with mem_ready tied 1 → states 0,1,2,4. ir_write and pc_write in cycle 0; reg_write = 1, reg_dst = 1, alu_op = 00 in WB; instr_done at cycle 3.
- LW (0100), mem_ready low 3 cycles in MEM → MEM lasts 4 cycles with mem_req = 1, mem_addr_sel = 1, mem_we = 0. WB has mem_to_reg = 1, reg_write = 1. Total 8 cycles.
- SW (0101) → MEM has mem_we = 1; instr_done in MEM; reg_write never 1. BEQ with zero = 1 → pc_write = 1, pc_src = 01 in EXEC; with zero = 0 → pc_write = 0 in EXEC, done in 3 cycles.
- JMP (0111) → pc_src = 10, pc_write = 1, instr_done in DECODE; back in FETCH next cycle. Opcode 1010 → FAULT from DECODE; fault stays 1 for 20 cycles; rst clears it to FETCH.
- Timeout with TIMEOUT = 15: mem_ready held 0 in FETCH → FAULT entered after exactly 15 FETCH cycles. Repeat with mem_ready = 1 on the 15th cycle → normal DECODE, no fault.
- Assert rst mid-MEM of an LW → next cycle state = FETCH; no reg_write, mem_we or instr_done issued for the aborted LW.
